aes_inv_core: RTL

//  Multi-cycle, FSM-based AES-128 decryption core (FIPS-197 InvCipher); the inverse of the encryption core.

---
 rtl/aes_inv_core.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_core.sv
// Multi-cycle AES-128 decryption core (InvCipher): one inverse-round datapath reused for
// every round, with the decryption round keys derived on the fly from the last round key.
module aes_inv_core #(
  parameter bit KEY_CACHE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_in_valid_i,
  output logic         data_in_ready_o,
  input  logic [127:0] key_in_i,
  input  logic [127:0] data_in_i,
  output logic         data_out_valid_o,
  output logic [127:0] data_out_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_EXPAND,
    S_INIT_ADD_KEY,
    S_PROCESS_ROUNDS,
    S_FINAL_ROUND,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------- GF(2^8) helpers
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = a;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // ---------------------------------------------------------------- key schedule helpers
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] forward_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undoes one forward step: recovers round key i-1 from round key i.
  function automatic logic [127:0] inv_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // ---------------------------------------------------------------- registers
  state_e         state_q;
  logic [3:0]     cnt_q;
  logic [127:0]   rk_q;
  logic [127:0]   blk_q;
  logic [127:0]   key_q;
  logic [127:0]   cache_key_q;
  logic [127:0]   cache_rk_q;
  logic           cache_valid_q;
  logic [127:0]   data_out_q;
  logic           valid_q;

  // ---------------------------------------------------------------- datapath
  logic [127:0]   isb_w;
  logic [127:0]   ark_w;
  logic [127:0]   imc_w;
  logic [127:0]   rk_fwd;
  logic [127:0]   rk_bwd;
  logic           cache_hit;

  // InvShiftRows folded into the byte select feeding InvSubBytes.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = R + 4 * ((C + 4 - R) % 4);
    assign isb_w[127-8*gi -: 8] = inv_sbox(blk_q[127-8*SRC -: 8]);
  end

  assign ark_w = isb_w ^ rk_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign imc_w[127-32*gi -: 32] = inv_mix_col(ark_w[127-32*gi -: 32]);
  end

  always_comb begin
    rk_fwd    = forward_expand(rk_q, rcon(cnt_q));
    rk_bwd    = inv_expand(rk_q, rcon(cnt_q));
    cache_hit = KEY_CACHE_EN && cache_valid_q && (key_in_i == cache_key_q);
  end

  assign data_in_ready_o  = (state_q == S_IDLE) && !rst;
  assign data_out_valid_o = valid_q;
  assign data_out_o       = data_out_q;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      rk_q          <= '0;
      blk_q         <= '0;
      key_q         <= '0;
      cache_key_q   <= '0;
      cache_rk_q    <= '0;
      cache_valid_q <= 1'b0;
      data_out_q    <= '0;
      valid_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (data_in_valid_i) begin
            key_q <= key_in_i;
            blk_q <= data_in_i;
            if (cache_hit) begin
              rk_q    <= cache_rk_q;
              cnt_q   <= 4'd10;
              state_q <= S_INIT_ADD_KEY;
            end else begin
              rk_q    <= key_in_i;
              cnt_q   <= 4'd1;
              state_q <= S_KEY_EXPAND;
            end
          end
        end
        S_KEY_EXPAND: begin
          rk_q <= rk_fwd;
          if (cnt_q == 4'd10) begin
            // cnt stays at 10 so the first backward step uses Rcon[10].
            cache_rk_q    <= rk_fwd;
            cache_key_q   <= key_q;
            cache_valid_q <= KEY_CACHE_EN;
            state_q       <= S_INIT_ADD_KEY;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_INIT_ADD_KEY: begin
          blk_q   <= blk_q ^ rk_q;
          rk_q    <= rk_bwd;
          cnt_q   <= 4'd9;
          state_q <= S_PROCESS_ROUNDS;
        end
        S_PROCESS_ROUNDS: begin
          blk_q <= imc_w;
          rk_q  <= rk_bwd;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_FINAL_ROUND;
        end
        S_FINAL_ROUND: begin
          blk_q   <= ark_w;
          state_q <= S_DONE;
        end
        S_DONE: begin
          data_out_q <= blk_q;
          valid_q    <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
